// File: rtl/pool_trace_pkg.sv
// pool_trace_pkg: shared types and helpers for the POOL handshake trace monitor.
//   traceState_e : monitor FSM states (IDLE, CAPTURE, DRAIN)
//   chWidth()    : channel-index width for a given channel count (at least 1 bit)
//   CH_LSB/TS_LSB: record field offsets for the default configuration;
//                  a record is {ts, ch_idx, payload} with the payload in the LSBs.
package pool_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } traceState_e;

  function automatic int chWidth(input int numCh);
    if (numCh <= 1) begin
      return 1;
    end else begin
      return $clog2(numCh);
    end
  endfunction

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int DEF_CH_W       = chWidth(DEF_NUM_CH);
  localparam int CH_LSB         = DEF_DATA_WIDTH;
  localparam int TS_LSB         = DEF_DATA_WIDTH + DEF_CH_W;

endpackage

// File: rtl/pool_trace_fifo.sv
// pool_trace_fifo: synchronous record FIFO with an extra pointer bit to tell
// full from empty. The head entry is visible on RdData while Empty is low.
//   Clk, Rst       : clock, synchronous active-high reset (clears pointers)
//   WrEn, WrData   : push one entry (caller guarantees !Full or a same-cycle pop)
//   RdEn, RdData   : pop the head entry
//   Full, Empty    : occupancy flags
module pool_trace_fifo
  import pool_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrEn,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEn,
  output logic [WIDTH-1:0] RdData,
  output logic             Full,
  output logic             Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wrPtr_r;
  logic [AW:0]      rdPtr_r;

  // Read and write pointer advance.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr_r <= {(AW+1){1'b0}};
      rdPtr_r <= {(AW+1){1'b0}};
    end else begin
      if (WrEn) begin
        wrPtr_r <= wrPtr_r + {{AW{1'b0}}, 1'b1};
      end
      if (RdEn) begin
        rdPtr_r <= rdPtr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem_r[wrPtr_r[AW-1:0]] <= WrData;
    end
  end

  assign RdData = mem_r[rdPtr_r[AW-1:0]];
  assign Empty  = (wrPtr_r == rdPtr_r);
  assign Full   = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);

endmodule

// File: rtl/pool_trace_mon.sv
// pool_trace_mon: passive multi-channel valid/ready trace monitor for POOL.
//   Clk, Rst            : clock, synchronous active-high reset
//   DumpStart/DumpEnd   : open/close the capture window (pulses)
//   ChEn/ChVal/ChRdy    : per-channel enable mask and snooped handshake
//   ChData              : snooped payloads, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
//   Trc_val/rdy/data    : record stream, record = {ts, ch_idx, payload}
//   Capturing           : high while in CAPTURE
//   DumpDone            : one-cycle pulse when the drain completes
//   DropCnt             : saturating count of records lost to back-pressure
module pool_trace_mon
  import pool_trace_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = chWidth(NUM_CH),
  parameter int REC_W      = TS_WIDTH + CH_W + DATA_WIDTH
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         DumpStart,
  input  logic                         DumpEnd,
  input  logic [NUM_CH-1:0]            ChEn,
  input  logic [NUM_CH-1:0]            ChVal,
  input  logic [NUM_CH-1:0]            ChRdy,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ChData,
  output logic                         Trc_val,
  input  logic                         Trc_rdy,
  output logic [REC_W-1:0]             Trc_data,
  output logic                         Capturing,
  output logic                         DumpDone,
  output logic [15:0]                  DropCnt
);

  traceState_e       state_r, nextState_s;
  logic [TS_WIDTH-1:0] ts_r;
  logic [NUM_CH-1:0] holdVld_r;
  logic [REC_W-1:0]  holdRec_r [NUM_CH];
  logic [CH_W-1:0]   ptr_r;
  logic [NUM_CH-1:0] fire_s, holdLoad_s, dropMask_s, grantOneHot_s;
  logic              grantVld_s;
  logic [CH_W-1:0]   grantIdx_s;
  logic [REC_W-1:0]  grantRec_s;
  logic [4:0]        dropNum_s;
  logic [16:0]       dropSum_s;
  logic              outVal_r, capturing_r, dumpDone_r;
  logic [REC_W-1:0]  outData_r, fifoRdData_s;
  logic [15:0]       dropCnt_r;
  logic              fifoFull_s, fifoEmpty_s, fifoWr_s, fifoRd_s;
  logic              outLoad_s, bypass_s, arbOpen_s, drainDone_s, startAcc_s;

  // Output stage and FIFO flow: the output register refills whenever it is
  // empty or being consumed; with an empty FIFO the granted record bypasses it.
  always_comb begin
    outLoad_s   = !outVal_r || Trc_rdy;
    fifoRd_s    = outLoad_s && !fifoEmpty_s;
    bypass_s    = outLoad_s && fifoEmpty_s;
    arbOpen_s   = !fifoFull_s || fifoRd_s;
    fifoWr_s    = grantVld_s && !bypass_s;
    startAcc_s  = (state_r == IDLE) && DumpStart;
    drainDone_s = (holdVld_r == {NUM_CH{1'b0}}) && fifoEmpty_s && outLoad_s;
  end

  // Fire detection, holding-register capture and drop accounting.
  always_comb begin
    if (state_r == CAPTURE) begin
      fire_s = ChVal & ChRdy & ChEn;
    end else begin
      fire_s = {NUM_CH{1'b0}};
    end
    holdLoad_s = fire_s & (~holdVld_r | grantOneHot_s);
    dropMask_s = fire_s & holdVld_r & ~grantOneHot_s;
    dropNum_s  = 5'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      dropNum_s = dropNum_s + {4'd0, dropMask_s[i]};
    end
    dropSum_s = {1'b0, dropCnt_r} + {12'd0, dropNum_s};
  end

  // Round-robin search starting at ptr_r; the lowest rotated offset wins.
  always_comb begin
    logic [CH_W-1:0] cand;
    cand       = {CH_W{1'b0}};
    grantVld_s = 1'b0;
    grantIdx_s = {CH_W{1'b0}};
    grantRec_s = {REC_W{1'b0}};
    if (arbOpen_s) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        cand = CH_W'((int'(ptr_r) + k) % NUM_CH);
        if (holdVld_r[cand]) begin
          grantVld_s = 1'b1;
          grantIdx_s = cand;
          grantRec_s = holdRec_r[cand];
        end else begin
          grantVld_s = grantVld_s;
        end
      end
    end else begin
      grantVld_s = 1'b0;
    end
  end

  // One-hot view of the grant for clearing the granted holding register.
  always_comb begin
    grantOneHot_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      grantOneHot_s[i] = grantVld_s && (grantIdx_s == CH_W'(i));
    end
  end

  // FSM next-state.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (DumpStart) nextState_s = CAPTURE;
        else           nextState_s = IDLE;
      end
      CAPTURE: begin
        if (DumpEnd) nextState_s = DRAIN;
        else         nextState_s = CAPTURE;
      end
      DRAIN: begin
        if (drainDone_s) nextState_s = IDLE;
        else             nextState_s = DRAIN;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // FSM state, timestamp, drop counter and status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      ts_r        <= {TS_WIDTH{1'b0}};
      dropCnt_r   <= 16'd0;
      capturing_r <= 1'b0;
      dumpDone_r  <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      capturing_r <= (nextState_s == CAPTURE);
      dumpDone_r  <= (state_r == DRAIN) && drainDone_s;
      if (startAcc_s) begin
        ts_r      <= {TS_WIDTH{1'b0}};
        dropCnt_r <= 16'd0;
      end else begin
        if (state_r == CAPTURE) ts_r <= ts_r + TS_WIDTH'(1);
        dropCnt_r <= dropSum_s[16] ? 16'hFFFF : dropSum_s[15:0];
      end
    end
  end

  // Holding registers and arbiter pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      holdVld_r <= {NUM_CH{1'b0}};
      ptr_r     <= {CH_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) holdRec_r[i] <= {REC_W{1'b0}};
    end else begin
      holdVld_r <= (holdVld_r & ~grantOneHot_s) | holdLoad_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (holdLoad_s[i]) begin
          holdRec_r[i] <= {ts_r, CH_W'(i), ChData[DATA_WIDTH*i +: DATA_WIDTH]};
        end
      end
      if (grantVld_s) ptr_r <= CH_W'((int'(grantIdx_s) + 1) % NUM_CH);
    end
  end

  // Registered trace output stage.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      outVal_r  <= 1'b0;
      outData_r <= {REC_W{1'b0}};
    end else if (outLoad_s) begin
      if (!fifoEmpty_s) begin
        outVal_r  <= 1'b1;
        outData_r <= fifoRdData_s;
      end else if (grantVld_s) begin
        outVal_r  <= 1'b1;
        outData_r <= grantRec_s;
      end else begin
        outVal_r  <= 1'b0;
      end
    end
  end

  pool_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk    (Clk),
    .Rst    (Rst),
    .WrEn   (fifoWr_s),
    .WrData (grantRec_s),
    .RdEn   (fifoRd_s),
    .RdData (fifoRdData_s),
    .Full   (fifoFull_s),
    .Empty  (fifoEmpty_s)
  );

  assign Trc_val   = outVal_r;
  assign Trc_data  = outData_r;
  assign Capturing = capturing_r;
  assign DumpDone  = dumpDone_r;
  assign DropCnt   = dropCnt_r;

endmodule

// File: doc/pool_trace_mon.md
# pool_trace_mon

Synthesizable multi-channel handshake trace monitor for the POOL datapath. It snoops up to NUM_CH valid/ready channels (for example CFG→POOL, GB→POOL, POOL→GB address, BF data and BF flag) during a DumpStart/DumpEnd window. Each completed transfer becomes a record tagged with channel index and timestamp, and records stream out one per beat on a single valid/ready trace port. It sits beside inst_POOL and never back-pressures the monitored channels.

## Interface
Parameters:
- NUM_CH, 4, number of monitored channels (1..8)
- DATA_WIDTH, 128, payload width per channel; narrower channels are zero-extended by the instantiator
- TS_WIDTH, 16, timestamp width
- FIFO_DEPTH, 16, record FIFO depth, power of 2, ≥2
- CH_W, max(1,$clog2(NUM_CH)), derived channel-index width
- REC_W, TS_WIDTH+CH_W+DATA_WIDTH, derived record width

Ports:
- Clk  in  1  clock; every flop is on posedge
- Rst  in  1  synchronous, active-high reset
- DumpStart  in  1  open the capture window (pulse)
- DumpEnd  in  1  close the capture window (pulse)
- ChEn  in  NUM_CH  per-channel capture enable mask, sampled every cycle
- ChVal  in  NUM_CH  monitored valid
- ChRdy  in  NUM_CH  monitored ready
- ChData  in  NUM_CH*DATA_WIDTH  monitored payload; channel i is bits [DATA_WIDTH*i +: DATA_WIDTH]
- Trc_val  out  1  trace record valid
- Trc_rdy  in  1  trace consumer ready
- Trc_data  out  REC_W  record = {ts, ch_idx, payload}, payload in the LSBs
- Capturing  out  1  high while the FSM is in CAPTURE
- DumpDone  out  1  one-cycle pulse when the drain completes
- DropCnt  out  16  count of records lost to back-pressure, saturating

## Operation
- FSM states: IDLE, CAPTURE, DRAIN.
  - IDLE → CAPTURE on DumpStart.
  - CAPTURE → DRAIN on DumpEnd.
  - DRAIN → IDLE when all holding registers and the FIFO are empty and Trc_val is 0. DumpDone pulses on that transition.
- DumpStart outside IDLE is ignored. DumpEnd outside CAPTURE is ignored. If DumpStart and DumpEnd arrive together in IDLE, the FSM enters CAPTURE and DumpEnd is ignored.
- DumpStart clears the timestamp counter and DropCnt. The counter increments every CAPTURE cycle and wraps modulo 2^TS_WIDTH.
- Fire condition for channel i: ChVal[i] & ChRdy[i] & ChEn[i] in a CAPTURE cycle. The DumpEnd cycle is included. The DumpStart cycle is excluded.
- Each channel has a one-entry holding register that captures {ts, i, payload} on fire.
  - If the register is still occupied when a new fire arrives, the new record is dropped and DropCnt increments. DropCnt increments by the number of simultaneous drops and saturates at 0xFFFF.
- Round-robin arbiter:
  - Moves at most one occupied holding register into the FIFO per cycle, and only when the FIFO is not full.
  - The pointer moves to one past the granted channel. Reset pointer is 0.
  - A holding register granted in cycle t may re-capture in the same cycle t.
- The FIFO feeds a registered output stage. Trc_data is held stable while Trc_val=1 and Trc_rdy=0.
- DRAIN keeps arbitrating and emitting but captures nothing.

## Timing
- Reset: state IDLE; Trc_val, Trc_data, Capturing, DumpDone and DropCnt are 0; FIFO, holding registers and arbiter pointer are cleared. Reset mid-capture or mid-drain discards all buffered records.
- Minimum latency: a fire at cycle t loads the holding register at t+1, writes the FIFO at t+1 (same-cycle grant), and raises Trc_val at t+2.
- Sustained throughput: one record per cycle when Trc_rdy=1. A simultaneous FIFO write and read at full is allowed.
- Capturing rises the cycle after DumpStart and falls the cycle after DumpEnd.
- DumpDone is asserted the cycle after the last record handshake (Trc_val & Trc_rdy).

## Structure
- Package pool_trace_pkg holds:
  - the state enum
  - a function computing CH_W from NUM_CH
  - record field offset localparams (TS_LSB, CH_LSB)
- Sub-module pool_trace_fifo: synchronous FIFO with a REC_W-wide entry, FIFO_DEPTH deep, full/empty flags, and an extra pointer bit for wrap detection.
- The arbiter and holding registers stay in the top module.

## Test plan
- Single channel, NUM_CH=4: DumpStart at cycle 10, one fire on ch2 at cycle 12 with payload 0xA5 → one record {ts=1, ch=2, data=0xA5}, Trc_val at cycle 14, DumpDone one cycle after the handshake.
- All 4 channels fire in the same cycle with Trc_rdy=1 → records emitted in order ch0, ch1, ch2, ch3 with identical ts and DropCnt=0; the next simultaneous burst starts at ch0 again, because the pointer is back at 0.
- Trc_rdy=0 while ch0 fires every cycle for 20 cycles, FIFO_DEPTH=16 → 16 records in the FIFO, 1 in the output stage, 1 in the holding register, DropCnt=2. Releasing Trc_rdy drains exactly 18 records in timestamp order.
- Window edges: fires in the DumpStart cycle and one cycle after DumpEnd are not captured; a fire in the DumpEnd cycle is captured.
- ChEn=4'b1011 with all channels firing → no ch2 records and DropCnt=0. TS_WIDTH=4 run of 20 cycles → ts wraps 15→0.
- Rst asserted mid-drain with 5 records buffered → Trc_val=0 on the next cycle, state IDLE, no DumpDone pulse, and a subsequent window starts clean.
